prco_lsu: RTL and testbench

//  Load/store stage directly downstream of the ALU. Takes the ALU's RAM-enable

---
 rtl/prco_lsu.sv | 146 ++++++++++++++
 tb/tb_prco_lsu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prco_lsu.sv
// Load/store stage behind the ALU.
// Runs one word access on the data-RAM request/acknowledge bus. The acknowledge
// latency is variable, and an access with no acknowledge is aborted after
// TIMEOUT cycles. An LW finishes with one register-file write. Every start
// produces exactly one q_done pulse.
module prco_lsu #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned REG_SEL_W = 3,
  parameter int unsigned TIMEOUT   = 255,
  // These encodings must match the ISA opcode table.
  parameter logic [4:0]  OP_LW     = 5'h08,
  parameter logic [4:0]  OP_SW     = 5'h09
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce_ram,
  input  logic [4:0]           i_op,
  input  logic [DATA_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_SEL_W-1:0] i_rd_sel,
  output logic                 q_mem_req,
  output logic                 q_mem_we,
  output logic [ADDR_W-1:0]    q_mem_addr,
  output logic [DATA_W-1:0]    q_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic                 q_reg_we,
  output logic [REG_SEL_W-1:0] q_reg_sel,
  output logic [DATA_W-1:0]    q_reg_data,
  output logic                 q_busy,
  output logic                 q_done,
  output logic                 q_err
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWb, StDone} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [REG_SEL_W-1:0]   sel_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   abort_q;
  logic                   err_q;
  logic                   bad_q;

  logic                   op_ok;
  logic                   start_ok;
  logic                   timeout_hit;

  assign op_ok       = (i_op == OP_LW) || (i_op == OP_SW);
  assign start_ok    = (state_q == StIdle) && i_ce_ram && op_ok;
  assign timeout_hit = (cnt_q == TimeoutLast);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An ack outside StReq has no effect on the state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StReq;
      end
      StReq: begin
        if (i_mem_ack) begin
          state_d = we_q ? StDone : StWb;
        end else if (timeout_hit) begin
          state_d = StDone;
        end
      end
      StWb:    state_d = StIdle;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: request latch, timeout counter, read-data capture, error pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      bad_q <= 1'b0;
      // A start while busy is dropped and only flagged. A bad opcode in idle
      // is completed at once as an error.
      if (i_ce_ram) begin
        if (state_q != StIdle) begin
          err_q <= 1'b1;
        end else if (!op_ok) begin
          err_q <= 1'b1;
          bad_q <= 1'b1;
        end
      end
      if (start_ok) begin
        we_q    <= (i_op == OP_SW);
        addr_q  <= i_addr[ADDR_W-1:0];
        wdata_q <= i_wdata;
        sel_q   <= i_rd_sel;
        cnt_q   <= '0;
        abort_q <= 1'b0;
      end
      if (state_q == StReq) begin
        cnt_q <= cnt_q + 16'd1;
        if (i_mem_ack) begin
          if (!we_q) rdata_q <= i_mem_rdata;
        end else if (timeout_hit) begin
          abort_q <= 1'b1;
        end
      end
    end
  end

  // Outputs: decoded from state. The buses are zeroed outside their valid phase.
  always_comb begin
    q_mem_req   = (state_q == StReq);
    q_mem_we    = q_mem_req && we_q;
    q_mem_addr  = q_mem_req ? addr_q : '0;
    q_mem_wdata = (q_mem_req && we_q) ? wdata_q : '0;
    q_reg_we    = (state_q == StWb);
    q_reg_sel   = q_reg_we ? sel_q : '0;
    q_reg_data  = q_reg_we ? rdata_q : '0;
    q_busy      = (state_q != StIdle);
    q_done      = (state_q == StWb) || (state_q == StDone) || bad_q;
    q_err       = ((state_q == StDone) && abort_q) || err_q;
  end

endmodule

// File: tb/tb_prco_lsu.sv
// Directed bench for prco_lsu. TIMEOUT is set to 8 so the abort path is short.
module tb_prco_lsu;

  localparam logic [4:0] OpLw  = 5'h08;
  localparam logic [4:0] OpSw  = 5'h09;
  localparam logic [4:0] OpAdd = 5'h00;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_ce_ram;
  logic [4:0]  i_op;
  logic [15:0] i_addr;
  logic [15:0] i_wdata;
  logic [2:0]  i_rd_sel;
  logic        q_mem_req;
  logic        q_mem_we;
  logic [15:0] q_mem_addr;
  logic [15:0] q_mem_wdata;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
  logic        q_reg_we;
  logic [2:0]  q_reg_sel;
  logic [15:0] q_reg_data;
  logic        q_busy;
  logic        q_done;
  logic        q_err;

  int checks   = 0;
  int failures = 0;

  prco_lsu #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .REG_SEL_W(3),
    .TIMEOUT  (8),
    .OP_LW    (OpLw),
    .OP_SW    (OpSw)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ce_ram   (i_ce_ram),
    .i_op       (i_op),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .i_rd_sel   (i_rd_sel),
    .q_mem_req  (q_mem_req),
    .q_mem_we   (q_mem_we),
    .q_mem_addr (q_mem_addr),
    .q_mem_wdata(q_mem_wdata),
    .i_mem_ack  (i_mem_ack),
    .i_mem_rdata(i_mem_rdata),
    .q_reg_we   (q_reg_we),
    .q_reg_sel  (q_reg_sel),
    .q_reg_data (q_reg_data),
    .q_busy     (q_busy),
    .q_done     (q_done),
    .q_err      (q_err)
  );

  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"},   32'(q_mem_req),   32'd0);
    check({tag, ".we"},    32'(q_mem_we),    32'd0);
    check({tag, ".addr"},  32'(q_mem_addr),  32'd0);
    check({tag, ".wdata"}, 32'(q_mem_wdata), 32'd0);
    check({tag, ".rwe"},   32'(q_reg_we),    32'd0);
    check({tag, ".rsel"},  32'(q_reg_sel),   32'd0);
    check({tag, ".rdata"}, 32'(q_reg_data),  32'd0);
    check({tag, ".busy"},  32'(q_busy),      32'd0);
    check({tag, ".done"},  32'(q_done),      32'd0);
    check({tag, ".err"},   32'(q_err),       32'd0);
  endtask

  initial begin
    i_reset = 1'b1; i_ce_ram = 1'b0; i_op = OpAdd; i_addr = '0; i_wdata = '0;
    i_rd_sel = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    step(); step();
    check_all_zero("reset");
    i_reset = 1'b0;
    step();

    // 1: LW with one-cycle ack.
    i_ce_ram = 1'b1; i_op = OpLw; i_addr = 16'h0010; i_rd_sel = 3'd3;
    step();
    i_ce_ram = 1'b0;
    check("t1.req",  32'(q_mem_req),  32'd1);
    check("t1.we",   32'(q_mem_we),   32'd0);
    check("t1.addr", 32'(q_mem_addr), 32'h0010);
    check("t1.done0", 32'(q_done),    32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 16'hBEEF;
    step();
    i_mem_ack = 1'b0;
    check("t1.rwe",   32'(q_reg_we),   32'd1);
    check("t1.rsel",  32'(q_reg_sel),  32'd3);
    check("t1.rdata", 32'(q_reg_data), 32'hBEEF);
    check("t1.done",  32'(q_done),     32'd1);
    check("t1.req_off", 32'(q_mem_req), 32'd0);
    check("t1.err",   32'(q_err),      32'd0);
    step();
    check("t1.idle_done", 32'(q_done),   32'd0);
    check("t1.idle_rwe",  32'(q_reg_we), 32'd0);
    check("t1.idle_busy", 32'(q_busy),   32'd0);

    // 2: SW, ack in the fifth request cycle.
    i_ce_ram = 1'b1; i_op = OpSw; i_addr = 16'h0004; i_wdata = 16'h1234;
    step();
    i_ce_ram = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2.req",   32'(q_mem_req),   32'd1);
      check("t2.we",    32'(q_mem_we),    32'd1);
      check("t2.addr",  32'(q_mem_addr),  32'h0004);
      check("t2.wdata", 32'(q_mem_wdata), 32'h1234);
      check("t2.rwe",   32'(q_reg_we),    32'd0);
      if (i == 4) i_mem_ack = 1'b1;
      step();
    end
    i_mem_ack = 1'b0;
    check("t2.done",    32'(q_done),    32'd1);
    check("t2.req_off", 32'(q_mem_req), 32'd0);
    check("t2.rwe_end", 32'(q_reg_we),  32'd0);
    check("t2.err",     32'(q_err),     32'd0);
    step();
    check("t2.done_off", 32'(q_done), 32'd0);

    // 3: LW with no ack aborts after exactly 8 request cycles.
    i_ce_ram = 1'b1; i_op = OpLw; i_addr = 16'h0077; i_rd_sel = 3'd6;
    step();
    i_ce_ram = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t3.req", 32'(q_mem_req), 32'd1);
      step();
    end
    check("t3.req_off", 32'(q_mem_req), 32'd0);
    check("t3.done",    32'(q_done),    32'd1);
    check("t3.err",     32'(q_err),     32'd1);
    check("t3.rwe",     32'(q_reg_we),  32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 16'hDEAD;
    step();
    i_mem_ack = 1'b0;
    check_all_zero("t3.late_ack");

    // 4: bad opcode completes immediately as an error.
    i_ce_ram = 1'b1; i_op = OpAdd; i_addr = 16'h0100;
    step();
    i_ce_ram = 1'b0;
    check("t4.err",  32'(q_err),     32'd1);
    check("t4.done", 32'(q_done),    32'd1);
    check("t4.req",  32'(q_mem_req), 32'd0);
    check("t4.busy", 32'(q_busy),    32'd0);
    step();
    check("t4.err_off",  32'(q_err),     32'd0);
    check("t4.done_off", 32'(q_done),    32'd0);
    check("t4.req_off",  32'(q_mem_req), 32'd0);

    // 5: a second start while busy is flagged and dropped.
    i_ce_ram = 1'b1; i_op = OpLw; i_addr = 16'h0020; i_rd_sel = 3'd5;
    step();
    check("t5.req", 32'(q_mem_req), 32'd1);
    i_op = OpSw; i_addr = 16'h0099; i_wdata = 16'hFFFF; i_rd_sel = 3'd1;
    step();
    i_ce_ram = 1'b0;
    check("t5.err",  32'(q_err),      32'd1);
    check("t5.req2", 32'(q_mem_req),  32'd1);
    check("t5.addr", 32'(q_mem_addr), 32'h0020);
    check("t5.we",   32'(q_mem_we),   32'd0);
    check("t5.done0", 32'(q_done),    32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 16'h5A5A;
    step();
    i_mem_ack = 1'b0;
    check("t5.err_off", 32'(q_err),      32'd0);
    check("t5.rwe",     32'(q_reg_we),   32'd1);
    check("t5.rsel",    32'(q_reg_sel),  32'd5);
    check("t5.rdata",   32'(q_reg_data), 32'h5A5A);
    check("t5.done",    32'(q_done),     32'd1);
    step();
    check_all_zero("t5.idle");

    // 6: reset mid-request clears everything; a following ack does nothing.
    i_ce_ram = 1'b1; i_op = OpSw; i_addr = 16'h0040; i_wdata = 16'hCAFE;
    step();
    i_ce_ram = 1'b0;
    step();
    check("t6.req", 32'(q_mem_req), 32'd1);
    i_reset = 1'b1;
    step();
    check_all_zero("t6.reset");
    i_reset = 1'b0; i_mem_ack = 1'b1;
    step();
    i_mem_ack = 1'b0;
    check_all_zero("t6.ack");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
